// File: rtl/window_spill_fill_unit.sv
// window_spill_fill_unit
// Moves one register window (r16..r31) between the register file and memory.
// A spill reads each register and stores it; a fill loads each word and writes
// it back into the register file. Every output is driven straight from a flop.
// Those flops are loaded with the decode of the next state, so each output
// matches the state it belongs to. Clr clears them at once, without waiting
// for a clock edge.
module window_spill_fill_unit #(
    parameter int NREGS      = 16,
    parameter int BASE_REG   = 16,
    parameter int WORD_BYTES = 4
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        start_spill,
    input  logic        start_fill,
    input  logic [1:0]  window,
    input  logic [31:0] sp,
    output logic [4:0]  rf_addr,
    output logic [1:0]  rf_window,
    input  logic [31:0] rf_rdata,
    output logic [31:0] rf_wdata,
    output logic        rf_we,
    output logic        mem_req,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done
);

    localparam int            KW     = $clog2(NREGS);
    localparam logic [KW-1:0] K_LAST = KW'(NREGS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SPILL_RD  = 3'd1,
        SPILL_REQ = 3'd2,
        FILL_REQ  = 3'd3,
        FILL_WR   = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [1:0]    win_q, win_d;
    logic [31:0]   sp_q, sp_d;

    logic [4:0]    rf_addr_q, rf_addr_d;
    logic [1:0]    rf_window_q, rf_window_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;
    logic          rf_we_q, rf_we_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_rw_q, mem_rw_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          active_d;

    // Next-state logic: sequencing, word counter, latched window/base and data capture.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        win_d       = win_q;
        sp_d        = sp_q;
        mem_wdata_d = mem_wdata_q;
        rf_wdata_d  = rf_wdata_q;
        case (state_q)
            IDLE: begin
                // Spill has priority; a simultaneous fill request is dropped.
                if (start_spill) begin
                    win_d   = window;
                    sp_d    = {sp[31:2], 2'b00};
                    k_d     = '0;
                    state_d = SPILL_RD;
                end else if (start_fill) begin
                    win_d   = window;
                    sp_d    = {sp[31:2], 2'b00};
                    k_d     = '0;
                    state_d = FILL_REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            SPILL_RD: begin
                mem_wdata_d = rf_rdata;
                state_d     = SPILL_REQ;
            end
            SPILL_REQ: begin
                if (mem_ack) begin
                    if (k_q == K_LAST) begin
                        state_d = DONE;
                    end else begin
                        k_d     = k_q + KW'(1);
                        state_d = SPILL_RD;
                    end
                end else begin
                    state_d = SPILL_REQ;
                end
            end
            FILL_REQ: begin
                if (mem_ack) begin
                    rf_wdata_d = mem_rdata;
                    state_d    = FILL_WR;
                end else begin
                    state_d = FILL_REQ;
                end
            end
            FILL_WR: begin
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = FILL_REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs line up with the state they belong to.
    always_comb begin
        active_d    = (state_d != IDLE);
        rf_addr_d   = 5'd0;
        rf_window_d = 2'd0;
        mem_addr_d  = 32'd0;
        if (active_d) begin
            rf_addr_d   = 5'(BASE_REG) + 5'(k_d);
            rf_window_d = win_d;
            mem_addr_d  = sp_d + (32'(k_d) * 32'(WORD_BYTES));
        end else begin
            rf_addr_d   = 5'd0;
            rf_window_d = 2'd0;
            mem_addr_d  = 32'd0;
        end
        mem_req_d = (state_d == SPILL_REQ) || (state_d == FILL_REQ);
        mem_rw_d  = (state_d == SPILL_REQ);
        rf_we_d   = (state_d == FILL_WR);
        busy_d    = active_d;
        done_d    = (state_d == DONE);
    end

    // State, counter, latched operands and registered outputs; Clr clears everything immediately.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q     <= IDLE;
            k_q         <= '0;
            win_q       <= 2'd0;
            sp_q        <= 32'd0;
            rf_addr_q   <= 5'd0;
            rf_window_q <= 2'd0;
            rf_wdata_q  <= 32'd0;
            rf_we_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            win_q       <= win_d;
            sp_q        <= sp_d;
            rf_addr_q   <= rf_addr_d;
            rf_window_q <= rf_window_d;
            rf_wdata_q  <= rf_wdata_d;
            rf_we_q     <= rf_we_d;
            mem_req_q   <= mem_req_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rf_addr   = rf_addr_q;
    assign rf_window = rf_window_q;
    assign rf_wdata  = rf_wdata_q;
    assign rf_we     = rf_we_q;
    assign mem_req   = mem_req_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_window_spill_fill_unit.sv
// Testbench for window_spill_fill_unit: register-file and memory models,
// scoreboard queues of expected memory transfers and register writes.
module tb_window_spill_fill_unit;

    logic        Clk = 1'b0;
    logic        Clr = 1'b1;
    logic        start_spill = 1'b0;
    logic        start_fill = 1'b0;
    logic [1:0]  window = 2'd0;
    logic [31:0] sp = 32'd0;
    logic [4:0]  rf_addr;
    logic [1:0]  rf_window;
    logic [31:0] rf_rdata;
    logic [31:0] rf_wdata;
    logic        rf_we;
    logic        mem_req;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        done;

    window_spill_fill_unit dut (
        .Clk(Clk), .Clr(Clr), .start_spill(start_spill), .start_fill(start_fill),
        .window(window), .sp(sp), .rf_addr(rf_addr), .rf_window(rf_window),
        .rf_rdata(rf_rdata), .rf_wdata(rf_wdata), .rf_we(rf_we), .mem_req(mem_req),
        .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    typedef struct { logic rw; logic [31:0] addr; logic [31:0] data; } mem_exp_t;
    typedef struct { logic [1:0] win; logic [4:0] addr; logic [31:0] data; } rf_exp_t;

    mem_exp_t mem_q[$];
    rf_exp_t  rfw_q[$];
    mem_exp_t me;
    rf_exp_t  re;

    int   vectors = 0;
    int   miscompares = 0;
    int   done_cnt = 0;
    logic spill_mode = 1'b0;
    logic fill_mode = 1'b0;

    // Register file model: combinational read, write on rising edge, bulk preload.
    logic [31:0] rf [4][32];
    logic [31:0] rf_init [4][32];
    logic        pre_load = 1'b0;
    always @(posedge Clk) begin
        if (pre_load) rf <= rf_init;
        else if (rf_we) rf[rf_window][rf_addr] <= rf_wdata;
    end
    assign rf_rdata = rf[rf_window][rf_addr];

    // Memory model: word at mem_addr_base + 4*i holds mem_data_base + i.
    logic [31:0] mem_addr_base = 32'd0;
    logic [31:0] mem_data_base = 32'd0;
    assign mem_rdata = mem_data_base + ((mem_addr - mem_addr_base) >> 2);

    // Acknowledge generator: tied high, or wait_cfg cycles after req rises.
    logic ack_tied = 1'b0;
    int   wait_cfg = 0;
    int   wait_cnt = 0;
    always @(posedge Clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end
    assign mem_ack = ack_tied | (mem_req & (wait_cnt >= wait_cfg));

    // Scoreboard monitor: pop and compare each memory transfer and register write.
    always @(negedge Clk) begin
        if (!Clr) begin
            if (mem_req && mem_ack) begin
                vectors++;
                if (mem_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL mem_xfer unexpected: rw=%0b addr=%h wdata=%h", mem_rw, mem_addr, mem_wdata);
                end else begin
                    me = mem_q.pop_front();
                    if (mem_rw !== me.rw || mem_addr !== me.addr || (me.rw && mem_wdata !== me.data)) begin
                        miscompares++;
                        $display("FAIL mem_xfer: got rw=%0b addr=%h wdata=%h, want rw=%0b addr=%h wdata=%h",
                                 mem_rw, mem_addr, mem_wdata, me.rw, me.addr, me.data);
                    end
                end
            end
            if (rf_we) begin
                vectors++;
                if (rfw_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rf_write unexpected: win=%0d addr=%0d data=%h", rf_window, rf_addr, rf_wdata);
                end else begin
                    re = rfw_q.pop_front();
                    if (rf_window !== re.win || rf_addr !== re.addr || rf_wdata !== re.data) begin
                        miscompares++;
                        $display("FAIL rf_write: got win=%0d addr=%0d data=%h, want win=%0d addr=%0d data=%h",
                                 rf_window, rf_addr, rf_wdata, re.win, re.addr, re.data);
                    end
                end
            end
            if (spill_mode && rf_we) begin
                miscompares++;
                $display("FAIL rf_we_in_spill: got 1 want 0");
            end
            if (fill_mode && mem_rw) begin
                miscompares++;
                $display("FAIL mem_rw_in_fill: got 1 want 0");
            end
            if (done) done_cnt++;
        end
    end

    task automatic load_rf();
        for (int w = 0; w < 4; w++)
            for (int r = 0; r < 32; r++)
                rf_init[w][r] = 32'hA000_0000 | (32'(w) << 8) | 32'(r);
        for (int i = 0; i < 16; i++) begin
            rf_init[1][16+i] = 32'd100 + 32'(i);
            rf_init[0][16+i] = 32'h0BAD_0000 + 32'(i);
        end
        @(negedge Clk); pre_load = 1'b1;
        @(negedge Clk); pre_load = 1'b0;
    endtask

    task automatic start_op(input logic s, input logic f, input logic [1:0] w, input logic [31:0] a);
        @(negedge Clk);
        start_spill = s; start_fill = f; window = w; sp = a;
        @(posedge Clk);
        #1;
        start_spill = 1'b0; start_fill = 1'b0;
    endtask

    // Wait for done; cycle numbers are counted from the edge that sampled start.
    task automatic run_op(input int budget, output int req_n, output int done_n);
        req_n = -1; done_n = -1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge Clk);
            if (req_n < 0 && mem_req) req_n = n;
            if (done) begin done_n = n; break; end
        end
    endtask

    task automatic test_reset();
        logic [31:0] outs [10];
        repeat (2) @(negedge Clk);
        outs = '{32'(rf_addr), 32'(rf_window), rf_wdata, 32'(rf_we), 32'(mem_req),
                 32'(mem_rw), mem_addr, mem_wdata, 32'(busy), 32'(done)};
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (outs[i] !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_out[%0d]: got %h want 0", i, outs[i]);
            end
        end
        Clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            vectors++;
            if (busy !== 1'b0 || mem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_after_reset: got busy=%0b mem_req=%0b want 0 0", busy, mem_req);
            end
        end
    endtask

    task automatic check_timing(input string name, input int req_n, input int want_req,
                                input int done_n, input int want_done);
        vectors++;
        if (req_n != want_req) begin
            miscompares++;
            $display("FAIL %s_first_req: got cycle %0d want %0d", name, req_n, want_req);
        end
        vectors++;
        if (done_n != want_done) begin
            miscompares++;
            $display("FAIL %s_done: got cycle %0d want %0d", name, done_n, want_done);
        end
        @(negedge Clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_done_pulse: got done=%0b busy=%0b want 0 0", name, done, busy);
        end
        vectors++;
        if (mem_q.size() != 0 || rfw_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_leftover: got %0d/%0d pending want 0/0", name, mem_q.size(), rfw_q.size());
        end
    endtask

    task automatic test_spill_zero_wait();
        int req_n, done_n;
        ack_tied = 1'b1; spill_mode = 1'b1;
        for (int i = 0; i < 16; i++)
            mem_q.push_back('{1'b1, 32'h1000 + 32'(4*i), 32'd100 + 32'(i)});
        start_op(1'b1, 1'b0, 2'd1, 32'h1000);
        run_op(100, req_n, done_n);
        check_timing("spill", req_n, 2, done_n, 33);
        spill_mode = 1'b0; ack_tied = 1'b0;
    endtask

    task automatic test_fill_wait();
        int req_n, done_n;
        logic [31:0] want;
        wait_cfg = 2; fill_mode = 1'b1;
        mem_addr_base = 32'h2000; mem_data_base = 32'd200;
        for (int i = 0; i < 16; i++) begin
            mem_q.push_back('{1'b0, 32'h2000 + 32'(4*i), 32'd0});
            rfw_q.push_back('{2'd2, 5'(16 + i), 32'd200 + 32'(i)});
        end
        start_op(1'b0, 1'b1, 2'd2, 32'h2003);
        run_op(200, req_n, done_n);
        check_timing("fill", req_n, 1, done_n, 65);
        for (int w = 0; w < 4; w++)
            for (int r = 0; r < 32; r++) begin
                want = (w == 2 && r >= 16) ? 32'd200 + 32'(r - 16) : rf_init[w][r];
                vectors++;
                if (rf[w][r] !== want) begin
                    miscompares++;
                    $display("FAIL fill_rf[%0d][%0d]: got %h want %h", w, r, rf[w][r], want);
                end
            end
        fill_mode = 1'b0; wait_cfg = 0;
    endtask

    task automatic test_wrap_simul();
        int req_n, done_n;
        ack_tied = 1'b1; spill_mode = 1'b1;
        for (int i = 0; i < 16; i++)
            mem_q.push_back('{1'b1, 32'hFFFF_FFF8 + 32'(4*i), 32'h0BAD_0000 + 32'(i)});
        start_op(1'b1, 1'b1, 2'd0, 32'hFFFF_FFF8);
        run_op(100, req_n, done_n);
        check_timing("wrap", req_n, 2, done_n, 33);
        repeat (5) @(negedge Clk);
        vectors++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_no_fill: got busy=%0b mem_req=%0b want 0 0", busy, mem_req);
        end
        spill_mode = 1'b0; ack_tied = 1'b0;
    endtask

    task automatic test_abort();
        int  done0;
        logic hit;
        logic [31:0] want;
        wait_cfg = 1; fill_mode = 1'b1;
        mem_addr_base = 32'h3000; mem_data_base = 32'd300;
        for (int i = 0; i < 5; i++) begin
            mem_q.push_back('{1'b0, 32'h3000 + 32'(4*i), 32'd0});
            rfw_q.push_back('{2'd3, 5'(16 + i), 32'd300 + 32'(i)});
        end
        done0 = done_cnt;
        hit = 1'b0;
        start_op(1'b0, 1'b1, 2'd3, 32'h3000);
        for (int n = 0; n < 200; n++) begin
            @(negedge Clk);
            if (mem_req && rf_addr == 5'd21) begin hit = 1'b1; break; end
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL abort_reach_word5: got timeout want mem_req at r21");
        end
        Clr = 1'b1;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || rf_we !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_async: got mem_req=%0b rf_we=%0b busy=%0b want 0 0 0", mem_req, rf_we, busy);
        end
        @(posedge Clk);
        @(negedge Clk);
        Clr = 1'b0; fill_mode = 1'b0;
        repeat (10) @(negedge Clk);
        vectors++;
        if (done_cnt != done0 || busy !== 1'b0 || mem_q.size() != 0 || rfw_q.size() != 0) begin
            miscompares++;
            $display("FAIL abort_quiet: got done_cnt=%0d busy=%0b pend=%0d/%0d want %0d 0 0/0",
                     done_cnt, busy, mem_q.size(), rfw_q.size(), done0);
        end
        for (int r = 16; r < 32; r++) begin
            want = (r < 21) ? 32'd300 + 32'(r - 16) : rf_init[3][r];
            vectors++;
            if (rf[3][r] !== want) begin
                miscompares++;
                $display("FAIL abort_rf[3][%0d]: got %h want %h", r, rf[3][r], want);
            end
        end
        wait_cfg = 0;
    endtask

    task automatic test_busy_ignore();
        int req_n, done_n, done0;
        ack_tied = 1'b1; spill_mode = 1'b1;
        for (int i = 0; i < 16; i++)
            mem_q.push_back('{1'b1, 32'h4000 + 32'(4*i), 32'd100 + 32'(i)});
        done0 = done_cnt;
        req_n = -1; done_n = -1;
        start_op(1'b1, 1'b0, 2'd1, 32'h4000);
        for (int n = 1; n <= 100; n++) begin
            @(negedge Clk);
            if (req_n < 0 && mem_req) req_n = n;
            if (n == 10) begin start_fill = 1'b1; window = 2'd2; sp = 32'h5000; end
            else start_fill = 1'b0;
            if (done) begin done_n = n; break; end
        end
        check_timing("busy_ignore", req_n, 2, done_n, 33);
        repeat (10) @(negedge Clk);
        vectors++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || done_cnt != done0 + 1) begin
            miscompares++;
            $display("FAIL busy_ignore_no_fill: got busy=%0b mem_req=%0b dones=%0d want 0 0 1",
                     busy, mem_req, done_cnt - done0);
        end
        spill_mode = 1'b0; ack_tied = 1'b0;
    endtask

    initial begin
        load_rf();
        test_reset();
        test_spill_zero_wait();
        test_fill_wait();
        test_wrap_simul();
        test_abort();
        test_busy_ignore();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/window_spill_fill_unit.md
Name: window_spill_fill_unit

Overview:
- Moves one SPARC register window between the register file and memory. A spill handles window overflow; a fill handles window underflow.
- Spill reads r16..r31 (locals l0-l7, ins i0-i7) of a chosen window through a register-file read port, then stores each word to the memory interface.
- Fill loads 16 words from memory and writes them into r16..r31 of the chosen window through the register-file write port.
- Sits between the trap/window-control logic and the register file; acts as the memory-side requester.

Parameters:
NREGS, 16, words transferred per operation
BASE_REG, 16, first register-file address transferred (r16 = l0)
WORD_BYTES, 4, memory address increment per word

Ports:
Clk  input  1  clock; all state changes on rising edge
Clr  input  1  asynchronous, active-high reset
start_spill  input  1  single-cycle request to spill a window
start_fill  input  1  single-cycle request to fill a window
window  input  2  target window, latched at start
sp  input  32  memory base address, latched at start
rf_addr  output  5  register address to register file (read and write)
rf_window  output  2  window select to register file
rf_rdata  input  32  combinational read data from register file for rf_addr/rf_window
rf_wdata  output  32  write data to register file
rf_we  output  1  register-file write enable, one cycle per word
mem_req  output  1  memory request, held until acknowledged
mem_rw  output  1  1 = store (spill), 0 = load (fill)
mem_addr  output  32  word address
mem_wdata  output  32  store data
mem_rdata  input  32  load data, valid when mem_ack = 1
mem_ack  input  1  memory acknowledge
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on completion

Behaviour:
- Reset (Clr=1, asynchronous):
  - State = IDLE, counter = 0.
  - All outputs = 0, including rf_addr, rf_window, mem_addr and mem_wdata.
  - Reset mid-operation aborts immediately: mem_req and rf_we drop without waiting for a clock edge, no further transfers occur, and done is not pulsed.
- States: IDLE, SPILL_RD, SPILL_REQ, FILL_REQ, FILL_WR, DONE.
- IDLE:
  - start_spill at an edge: latch window, latch sp with bits [1:0] forced to 00, clear counter k, go to SPILL_RD.
  - else start_fill at an edge: same latching, go to FILL_REQ.
  - Both starts high: spill wins and fill is dropped.
  - Starts outside IDLE are ignored; they are neither queued nor restarted.
- Per-word outputs in every active state:
  - rf_addr = BASE_REG + k.
  - rf_window = latched window.
  - mem_addr = sp_latched + WORD_BYTES*k, modulo 2^32; crossing address 0xFFFFFFFC wraps to 0.
- SPILL_RD: one cycle. At the edge, capture rf_rdata into mem_wdata and go to SPILL_REQ.
- SPILL_REQ:
  - mem_req=1, mem_rw=1; mem_addr and mem_wdata held stable.
  - On an edge with mem_ack=1: if k=NREGS-1 go to DONE, else k=k+1 and go to SPILL_RD.
  - mem_ack=0: stay, with any number of wait cycles.
- FILL_REQ:
  - mem_req=1, mem_rw=0.
  - On an edge with mem_ack=1: capture mem_rdata into rf_wdata and go to FILL_WR.
- FILL_WR:
  - rf_we=1 for exactly one cycle; the register file writes at the closing edge.
  - That edge: if k=NREGS-1 go to DONE, else k=k+1 and go to FILL_REQ.
- DONE: done=1 and busy=1 for one cycle, then go to IDLE.
- Handshake rules:
  - mem_ack is sampled only while mem_req=1; ack arriving with req low is ignored.
  - A same-cycle ack completes the transfer at that edge.
  - mem_req falls in the cycle after the acknowledging edge.
- Latency with zero-wait ack (start sampled at edge E):
  - Spill: first mem_req in cycle E+2; 2 cycles per word; done in cycle E+33.
  - Fill: first mem_req in cycle E+1; 2 cycles per word; done in cycle E+33.
  - Each ack wait cycle adds exactly 1 cycle.
- rf_we never rises during a spill; mem_rw never equals 1 during a fill.

Test Plan:
- Reset: Clr=1 -> all outputs 0. Then Clr=0 with no start -> busy=0, mem_req=0 indefinitely.
- Spill, zero wait: window 1 preloaded so r16..r31 = 100..115; sp=0x1000, ack tied high -> 16 stores to 0x1000..0x103C carrying data 100..115 in order; done in cycle E+33; rf_we never 1.
- Fill with waits: window 2, sp=0x2003, memory 0x2000..0x203C holds 200..215, ack 2 cycles after each req -> addresses aligned to 0x2000; r16..r31 of window 2 = 200..215; windows 0, 1, 3 unchanged; total 65 cycles to done.
- Wrap and simultaneous start: sp=0xFFFFFFF8 with start_spill and start_fill high together -> spill only; addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, ... 0x34.
- Abort: Clr pulsed during word 5 of a fill while mem_req=1 -> mem_req and rf_we drop asynchronously; registers r21..r31 untouched; no done.
- Busy-ignore: start_fill asserted mid-spill -> ignored; spill completes normally and no fill follows.
